// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture stream.
package cam_pkg;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } cap_state_e;

  localparam int FRAME_CNT_W = 16;

  function automatic int pix_w(input int data_w, input int bytes_per_pix);
    return data_w * bytes_per_pix;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Polarity-normalising edge detector: act is the asserted level, rise/fall
// compare it against the previous pclk sample.
module cam_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic pclk,
  input  logic reset,
  input  logic sig,
  output logic act,
  output logic rise,
  output logic fall
);

  logic act_q;

  assign act = ~(sig ^ POL);

  always_ff @(posedge pclk) begin
    if (reset) act_q <= 1'b0;
    else       act_q <= act;
  end

  assign rise = act & ~act_q;
  assign fall = ~act & act_q;

endmodule

// File: rtl/cam_capture_stream.sv
// Camera byte stream to pixel-FIFO writer with frame/line geometry checks.
// Optional 2x2 decimation is compiled in with CAM_CAPTURE_DECIMATE_EN.
//
// state     | meaning
// WAIT_SYNC | idle until vsync blanking ends with capture_en set
// ACTIVE    | assembling pixels and writing the FIFO until blanking starts
module cam_capture_stream
  import cam_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter bit VSYNC_POL     = 1'b1
) (
  input  logic                                        pclk,
  input  logic                                        reset,
  input  logic                                        capture_en,
  input  logic                                        vsync,
  input  logic                                        href,
  input  logic [DATA_W-1:0]                           d,
  input  logic                                        fifo_full,
  input  logic                                        clear_status,
  output logic                                        fifo_wr_en,
  output logic [pix_w(DATA_W, BYTES_PER_PIX)-1:0]     fifo_wr_data,
  output logic                                        pix_sof,
  output logic                                        pix_eol,
  output logic                                        frame_start,
  output logic                                        frame_end,
  output logic [FRAME_CNT_W-1:0]                      frame_count,
  output logic                                        line_err,
  output logic                                        overflow
);

  localparam int PIX_W = pix_w(DATA_W, BYTES_PER_PIX);

  // Input geometry: with decimation the camera delivers twice the output size.
`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam int H_IN  = 2 * H_ACTIVE;
  localparam int V_IN  = 2 * V_ACTIVE;
  localparam int EOL_X = H_IN - 2;
`else
  localparam int H_IN  = H_ACTIVE;
  localparam int V_IN  = V_ACTIVE;
  localparam int EOL_X = H_ACTIVE - 1;
`endif

  localparam int X_W  = $clog2(H_IN + 2);
  localparam int Y_W  = $clog2(V_IN + 2);
  localparam int BC_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

  localparam logic [X_W-1:0]  X_END   = X_W'(H_IN);
  localparam logic [X_W-1:0]  X_SAT   = X_W'(H_IN + 1);
  localparam logic [X_W-1:0]  X_EOL   = X_W'(EOL_X);
  localparam logic [Y_W-1:0]  Y_END   = Y_W'(V_IN);
  localparam logic [Y_W-1:0]  Y_SAT   = Y_W'(V_IN + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTES_PER_PIX - 1);

  cap_state_e state, state_nxt;
  logic       start_nxt, end_nxt;

  logic vs_act, vs_rise, vs_fall;
  logic hr_act, hr_rise, hr_fall;

  logic [BC_W-1:0]  bc, bc_eff;
  logic [X_W-1:0]   x, x_inc;
  logic [Y_W-1:0]   y, y_inc, y_line;
  logic [PIX_W-1:0] asm_nxt;

  logic active, byte_take, pix_done, in_geo, keep, pix_write, wr_go;
  logic line_bad, vs_err, err_set, ovf_set;

  cam_sync_edge #(.POL(VSYNC_POL)) u_vs_edge (
    .pclk  (pclk),
    .reset (reset),
    .sig   (vsync),
    .act   (vs_act),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  cam_sync_edge #(.POL(1'b1)) u_hr_edge (
    .pclk  (pclk),
    .reset (reset),
    .sig   (href),
    .act   (hr_act),
    .rise  (hr_rise),
    .fall  (hr_fall)
  );

  always_ff @(posedge pclk) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (vs_fall && capture_en) begin
          state_nxt = ACTIVE;
          start_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_nxt = WAIT_SYNC;
          end_nxt   = 1'b1;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  // Blanking overrides href, so a pixel in flight at vs_rise is dropped.
  assign active    = (state == ACTIVE);
  assign bc_eff    = hr_rise ? '0 : bc;
  assign byte_take = active & hr_act & ~vs_act;
  assign pix_done  = byte_take & (bc_eff == BC_LAST);
  assign in_geo    = (x < X_END) & (y < Y_END);
  assign pix_write = pix_done & in_geo & keep;
  assign wr_go     = pix_write & ~fifo_full;

`ifdef CAM_CAPTURE_DECIMATE_EN
  assign keep = ~x[0] & ~y[0];
`else
  assign keep = 1'b1;
`endif

  // Counters saturate one past the end so oversize geometry stays detectable.
  assign x_inc  = (x == X_SAT) ? x : x + X_W'(1);
  assign y_inc  = (y == Y_SAT) ? y : y + Y_W'(1);
  assign y_line = hr_fall ? y_inc : y;

  assign line_bad = active & hr_fall & ((x != X_END) | (bc != '0));
  assign vs_err   = active & vs_rise & ((y_line != Y_END) | hr_act);
  assign err_set  = (pix_done & ~in_geo) | line_bad | vs_err;
  assign ovf_set  = pix_write & fifo_full;

  generate
    if (BYTES_PER_PIX == 1) begin : g_single
      assign asm_nxt = d;
    end else begin : g_multi
      localparam int HEAD_W = (BYTES_PER_PIX - 1) * DATA_W;
      logic [HEAD_W-1:0] head_q;

      always_ff @(posedge pclk) begin
        if (reset)          head_q <= '0;
        else if (byte_take) head_q <= asm_nxt[HEAD_W-1:0];
      end

      assign asm_nxt = {head_q, d};
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (reset) begin
      bc           <= '0;
      x            <= '0;
      y            <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_count  <= '0;
      line_err     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fifo_wr_en  <= wr_go;
      pix_sof     <= wr_go & (x == '0) & (y == '0);
      pix_eol     <= wr_go & (x == X_EOL);
      frame_start <= start_nxt;
      frame_end   <= end_nxt;
      line_err    <= (line_err & ~clear_status) | err_set;
      overflow    <= (overflow & ~clear_status) | ovf_set;
      if (wr_go)   fifo_wr_data <= asm_nxt;
      if (end_nxt) frame_count  <= frame_count + FRAME_CNT_W'(1);

      if (!active || vs_rise) begin
        bc <= '0;
        x  <= '0;
        y  <= '0;
      end else if (hr_fall) begin
        bc <= '0;
        x  <= '0;
        y  <= y_inc;
      end else if (byte_take) begin
        if (pix_done) begin
          bc <= '0;
          x  <= x_inc;
        end else begin
          bc <= bc_eff + BC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_stream.sv
// Self-checking bench for cam_capture_stream (4x2 frames, 2 bytes per pixel).
module tb_cam_capture_stream;

  localparam int DW  = 8;
  localparam int BPP = 2;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int PW  = DW * BPP;

  logic          pclk = 1'b0;
  logic          reset, capture_en, vsync, href, fifo_full, clear_status;
  logic [DW-1:0] d;
  logic          fifo_wr_en;
  logic [PW-1:0] fifo_wr_data;
  logic          pix_sof, pix_eol, frame_start, frame_end;
  logic [15:0]   frame_count;
  logic          line_err, overflow;

  int checks = 0;
  int errors = 0;

  logic [PW+1:0] act_q[$];
  logic [PW+1:0] exp_q[$];
  int            n_fs = 0, n_fe = 0, n_stray = 0;
  int            exp_frames = 0;
  bit            exp_err = 1'b0, exp_ovf = 1'b0;
  int            line_bytes[8];
  bit            full_pix[8][8];
  logic [7:0]    fb[8][16];

  cam_capture_stream #(
    .DATA_W(DW), .BYTES_PER_PIX(BPP), .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b1)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .capture_en   (capture_en),
    .vsync        (vsync),
    .href         (href),
    .d            (d),
    .fifo_full    (fifo_full),
    .clear_status (clear_status),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .frame_count  (frame_count),
    .line_err     (line_err),
    .overflow     (overflow)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (fifo_wr_en) act_q.push_back({fifo_wr_data, pix_sof, pix_eol});
    if ((pix_sof || pix_eol) && !fifo_wr_en) n_stray++;
    if (frame_start) n_fs++;
    if (frame_end) n_fe++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_geom(input int nb);
    for (int l = 0; l < 8; l++) begin
      line_bytes[l] = nb;
      for (int p = 0; p < 8; p++) full_pix[l][p] = 1'b0;
    end
  endtask

  task automatic pulse_clear;
    clear_status = 1'b1;
    step;
    clear_status = 1'b0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Builds the camera frame, predicts its FIFO writes/flags, then drives it.
  task automatic run_frame(input int nlines, input bit cap_fall, input bit cap_mid, input bit seq);
    int k;
    logic [PW-1:0] w;
    k = 0;
    for (int l = 0; l < nlines; l++)
      for (int b = 0; b < line_bytes[l]; b++) begin
        fb[l][b] = seq ? 8'(8'h12 + 8'(k * 34)) : 8'($urandom);
        k++;
      end
    if (cap_fall) begin
      for (int l = 0; l < nlines; l++) begin
        if (line_bytes[l] != H * BPP) exp_err = 1'b1;
        for (int p = 0; p < line_bytes[l] / BPP; p++)
          if (p < H && l < V) begin
            if (full_pix[l][p]) exp_ovf = 1'b1;
            else begin
              w = '0;
              for (int j = 0; j < BPP; j++) w = {w[PW-DW-1:0], fb[l][p*BPP+j]};
              exp_q.push_back({w, (p == 0 && l == 0), (p == H - 1)});
            end
          end
      end
      if (nlines != V) exp_err = 1'b1;
      exp_frames++;
    end
    capture_en = cap_fall;
    vsync = 1'b0;
    step;
    step;
    for (int l = 0; l < nlines; l++) begin
      if (l == 1 && cap_mid) capture_en = 1'b1;
      for (int b = 0; b < line_bytes[l]; b++) begin
        href = 1'b1;
        d = fb[l][b];
        fifo_full = ((b % BPP) == BPP - 1) && full_pix[l][b/BPP];
        step;
      end
      href = 1'b0;
      fifo_full = 1'b0;
      d = 8'($urandom);
      repeat (3) step;
    end
    vsync = 1'b1;
    repeat (5) step;
  endtask

  task automatic test_reset;
    reset = 1'b1; capture_en = 1'b0; vsync = 1'b1; href = 1'b0;
    d = 8'h5A; fifo_full = 1'b0; clear_status = 1'b0;
    repeat (3) step;
    reset = 1'b0;
    checks++;
    if ({fifo_wr_en, pix_sof, pix_eol, frame_start, frame_end} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {fifo_wr_en, pix_sof, pix_eol, frame_start, frame_end});
    end
    checks++;
    if (fifo_wr_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", fifo_wr_data); end
    checks++;
    if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    checks++;
    if ({line_err, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {line_err, overflow}); end
    repeat (4) step;
    checks++;
    if (n_fs !== 0) begin errors++; $display("FAIL reset_no_start got %0d want 0", n_fs); end
  endtask

  task automatic test_basic;
    set_geom(H * BPP);
    run_frame(V, 1'b1, 1'b0, 1'b1);
    checks++;
    if (act_q.size() !== 8) begin errors++; $display("FAIL basic_writes got %0d want 8", act_q.size()); end
    checks++;
    if (act_q.size() > 0 && act_q[0] !== {16'h1234, 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_first got %h want %h", act_q[0], {16'h1234, 1'b1, 1'b0});
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    run_frame(V, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic2_writes got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic2_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    checks++;
    if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL basic_frame_count got %0d want %0d", frame_count, exp_frames); end
    checks++;
    if ({line_err, overflow} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {line_err, overflow}); end
  endtask

  task automatic test_capture_gate;
    int fs0;
    fs0 = n_fs;
    set_geom(H * BPP);
    run_frame(V, 1'b0, 1'b1, 1'b0);
    checks++;
    if (act_q.size() !== 0) begin errors++; $display("FAIL gate_writes got %0d want 0", act_q.size()); end
    checks++;
    if (n_fs !== fs0) begin errors++; $display("FAIL gate_start got %0d want %0d", n_fs, fs0); end
    act_q.delete(); exp_q.delete();
    run_frame(V, 1'b1, 1'b0, 1'b0);
    checks++;
    if (n_fs !== fs0 + 1) begin errors++; $display("FAIL gate_start2 got %0d want %0d", n_fs, fs0 + 1); end
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL gate2_writes got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL gate2_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_line;
    pulse_clear;
    set_geom(H * BPP);
    line_bytes[0] = 3;
    run_frame(V, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_q.size() !== 5) begin errors++; $display("FAIL short_writes got %0d want 5", act_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    checks++;
    if ({line_err, overflow} !== {exp_err, exp_ovf}) begin
      errors++; $display("FAIL short_flags got %b want %b", {line_err, overflow}, {exp_err, exp_ovf});
    end
  endtask

  task automatic test_overflow;
    pulse_clear;
    set_geom(H * BPP);
    full_pix[0][1] = 1'b1;
    run_frame(V, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_q.size() !== 7) begin errors++; $display("FAIL ovf_writes got %0d want 7", act_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    checks++;
    if ({line_err, overflow} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {line_err, overflow}); end
  endtask

  task automatic test_oversize;
    pulse_clear;
    set_geom(6 * BPP);
    run_frame(V + 1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_q.size() !== H * V) begin errors++; $display("FAIL big_writes got %0d want %0d", act_q.size(), H * V); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL big_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    checks++;
    if (line_err !== 1'b1) begin errors++; $display("FAIL big_line_err got %b want 1", line_err); end
    pulse_clear;
    checks++;
    if ({line_err, overflow} !== 2'b00) begin errors++; $display("FAIL big_clear got %b want 00", {line_err, overflow}); end
  endtask

  task automatic test_mid_reset;
    int fe0;
    logic [PW+1:0] first;
    for (int b = 0; b < 16; b++) fb[0][b] = 8'($urandom);
    first = {fb[0][0], fb[0][1], 1'b1, 1'b0};
    capture_en = 1'b1;
    vsync = 1'b0;
    step; step;
    for (int b = 0; b < 3; b++) begin href = 1'b1; d = fb[0][b]; step; end
    d = fb[0][3];
    reset = 1'b1;
    step;
    reset = 1'b0;
    @(negedge pclk);
    checks++;
    if ({fifo_wr_en, pix_sof, pix_eol, frame_start, frame_end, line_err, overflow} !== 7'b0 || frame_count !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs got %b/%0d want 0000000/0",
        {fifo_wr_en, pix_sof, pix_eol, frame_start, frame_end, line_err, overflow}, frame_count);
    end
    checks++;
    if (act_q.size() !== 1 || act_q[0] !== first) begin
      errors++; $display("FAIL midrst_pre_write got %0d writes want 1 of %h", act_q.size(), first);
    end
    act_q.delete(); exp_q.delete();
    fe0 = n_fe;
    exp_frames = 0; exp_err = 1'b0; exp_ovf = 1'b0;
    for (int b = 4; b < 8; b++) begin href = 1'b1; d = fb[0][b]; step; end
    href = 1'b0; repeat (3) step;
    for (int b = 0; b < 8; b++) begin href = 1'b1; d = 8'($urandom); step; end
    href = 1'b0; repeat (3) step;
    vsync = 1'b1; repeat (5) step;
    checks++;
    if (act_q.size() !== 0 || n_fe !== fe0) begin
      errors++; $display("FAIL midrst_quiet got %0d writes %0d ends want 0 writes %0d ends", act_q.size(), n_fe, fe0);
    end
    act_q.delete();
    set_geom(H * BPP);
    run_frame(V, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_resume got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    act_q.delete(); exp_q.delete();
    checks++;
    if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL midrst_frame_count got %0d want %0d", frame_count, exp_frames); end
  endtask

  task automatic test_random;
    int nl, r;
    bit cap;
    for (int f = 0; f < 10; f++) begin
      pulse_clear;
      r = $urandom_range(0, 5);
      nl = (r == 0) ? V + 1 : (r == 1) ? 1 : V;
      for (int l = 0; l < 8; l++) begin
        line_bytes[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : H * BPP;
        for (int p = 0; p < 8; p++) full_pix[l][p] = ($urandom_range(0, 5) == 0);
      end
      cap = ($urandom_range(0, 3) != 0);
      run_frame(nl, cap, 1'b0, 1'b0);
      checks++;
      if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_writes got %0d want %0d", f, act_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < act_q.size()) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word[%0d] got %h want %h", f, i, act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
      checks++;
      if ({line_err, overflow} !== {exp_err, exp_ovf}) begin
        errors++; $display("FAIL rand%0d_flags got %b want %b", f, {line_err, overflow}, {exp_err, exp_ovf});
      end
      checks++;
      if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL rand%0d_frame_count got %0d want %0d", f, frame_count, exp_frames); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_capture_gate;
    test_short_line;
    test_overflow;
    test_oversize;
    test_mid_reset;
    test_random;
    checks++;
    if (n_stray !== 0) begin errors++; $display("FAIL sideband_without_write got %0d want 0", n_stray); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
